// File: rtl/multicycle_controller.sv
// multicycle_controller
// Control FSM for a multicycle MIPS-style datapath with a memory ready
// handshake and a per-state wait timeout.
// Optional feature: define MC_CTRL_BNE_EN to decode bne (op 000101) through
// the BNEEX state. Without it, op 000101 is flagged illegal and branchne is 0.
// CNT_W must be wide enough to hold TIMEOUT.
module multicycle_controller #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic       mem_timeout,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    // TIMEOUT of 0 turns the handshake timeout off entirely.
    localparam bit             TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    // Supported R-type function codes.
    function automatic logic funct_legal(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_legal = 1'b1;
            default:                                               funct_legal = 1'b0;
        endcase
    endfunction

    // ALU operation from the aluop class and, for R-type, the funct field.
    function automatic logic [2:0] alu_decode(input logic [1:0] aluop, input logic [5:0] f);
        case (aluop)
            2'b00: alu_decode = 3'b010;
            2'b01: alu_decode = 3'b110;
            2'b10: begin
                case (f)
                    6'b100000: alu_decode = 3'b010;
                    6'b100010: alu_decode = 3'b110;
                    6'b100100: alu_decode = 3'b000;
                    6'b100101: alu_decode = 3'b001;
                    6'b101010: alu_decode = 3'b111;
                    default:   alu_decode = 3'b010;
                endcase
            end
            default: alu_decode = 3'b010;
        endcase
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [1:0]       aluop_s;
    logic             pcwrite_s;
    logic             branch_s;
    logic             branchne_s;
    logic             irwrite_s;
    logic             memwrite_s;
    logic             regwrite_s;
    logic             illegal_s;
    logic             timeout_s;
    logic             wait_s;
    logic             expired_s;

    // The wait budget is used up when the last allowed cycle passes without ready.
    assign expired_s = TO_EN && (cnt_r == TO_LAST) && !mem_ready;

    // Next-state and raw control decode for the current state.
    always_comb begin
        state_next_s = state_r;
        aluop_s      = 2'b00;
        pcwrite_s    = 1'b0;
        branch_s     = 1'b0;
        branchne_s   = 1'b0;
        irwrite_s    = 1'b0;
        memwrite_s   = 1'b0;
        regwrite_s   = 1'b0;
        illegal_s    = 1'b0;
        timeout_s    = 1'b0;
        wait_s       = 1'b0;
        iord         = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        case (state_r)
            FETCH: begin
                alusrcb = 2'b01;
                wait_s  = 1'b1;
                if (mem_ready) begin
                    irwrite_s    = 1'b1;
                    pcwrite_s    = 1'b1;
                    state_next_s = DECODE;
                end else if (expired_s) begin
                    timeout_s    = 1'b1;
                    state_next_s = FETCH;
                end else begin
                    state_next_s = FETCH;
                end
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_next_s = MEMADR;
                    OP_RTYPE:     state_next_s = RTYPEEX;
                    OP_BEQ:       state_next_s = BEQEX;
                    OP_ADDI:      state_next_s = ADDIEX;
                    OP_J:         state_next_s = JEX;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       state_next_s = BNEEX;
`endif
                    default: begin
                        illegal_s    = 1'b1;
                        state_next_s = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (op == OP_LW) begin
                    state_next_s = MEMRD;
                end else begin
                    state_next_s = MEMWR;
                end
            end
            MEMRD: begin
                iord   = 1'b1;
                wait_s = 1'b1;
                if (mem_ready) begin
                    state_next_s = MEMWB;
                end else if (expired_s) begin
                    timeout_s    = 1'b1;
                    state_next_s = FETCH;
                end else begin
                    state_next_s = MEMRD;
                end
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
                wait_s     = 1'b1;
                if (mem_ready) begin
                    state_next_s = FETCH;
                end else if (expired_s) begin
                    memwrite_s   = 1'b0;
                    timeout_s    = 1'b1;
                    state_next_s = FETCH;
                end else begin
                    state_next_s = MEMWR;
                end
            end
            MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_s   = 1'b1;
                state_next_s = FETCH;
            end
            RTYPEEX: begin
                alusrca      = 1'b1;
                aluop_s      = 2'b10;
                state_next_s = RTYPEWB;
            end
            RTYPEWB: begin
                regdst       = 1'b1;
                state_next_s = FETCH;
                if (funct_legal(funct)) begin
                    regwrite_s = 1'b1;
                end else begin
                    illegal_s  = 1'b1;
                end
            end
            BEQEX: begin
                alusrca      = 1'b1;
                aluop_s      = 2'b01;
                pcsrc        = 2'b01;
                branch_s     = 1'b1;
                state_next_s = FETCH;
            end
            ADDIEX: begin
                alusrca      = 1'b1;
                alusrcb      = 2'b10;
                state_next_s = ADDIWB;
            end
            ADDIWB: begin
                regwrite_s   = 1'b1;
                state_next_s = FETCH;
            end
            JEX: begin
                pcsrc        = 2'b10;
                pcwrite_s    = 1'b1;
                state_next_s = FETCH;
            end
`ifdef MC_CTRL_BNE_EN
            BNEEX: begin
                alusrca      = 1'b1;
                aluop_s      = 2'b01;
                pcsrc        = 2'b01;
                branchne_s   = 1'b1;
                state_next_s = FETCH;
            end
`endif
            default: begin
                state_next_s = FETCH;
            end
        endcase
    end

    // Wait counter: restart on every state change or timeout, count idle waits.
    always_comb begin
        if ((state_next_s != state_r) || timeout_s) begin
            cnt_next_s = '0;
        end else if (wait_s && !mem_ready && (cnt_r != '1)) begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // State and wait counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= FETCH;
            cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Side-effecting strobes are held off while reset is asserted.
    always_comb begin
        if (reset_n) begin
            pcen        = pcwrite_s | (branch_s & zero) | (branchne_s & ~zero);
            irwrite     = irwrite_s;
            memwrite    = memwrite_s;
            regwrite    = regwrite_s;
            illegal     = illegal_s;
            mem_timeout = timeout_s;
        end else begin
            pcen        = 1'b0;
            irwrite     = 1'b0;
            memwrite    = 1'b0;
            regwrite    = 1'b0;
            illegal     = 1'b0;
            mem_timeout = 1'b0;
        end
    end

    assign alucontrol = alu_decode(aluop_s, funct);
    assign state      = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller (TIMEOUT=4).
// Outputs are packed into one observation vector:
// {state[4], pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,
//  alusrcb[2], pcsrc[2], alucontrol[3], illegal, mem_timeout}
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal, mem_timeout;
    logic [3:0] state;

    int n_cmp = 0;
    int n_err = 0;

    logic [20:0] obs;
    assign obs = {state, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                  alusrcb, pcsrc, alucontrol, illegal, mem_timeout};

    localparam logic [20:0] V_F_RDY   = {4'd0,  8'b1001_0000, 2'b01, 2'b00, 3'b010, 2'b00};
    localparam logic [20:0] V_F_WAIT  = {4'd0,  8'b0000_0000, 2'b01, 2'b00, 3'b010, 2'b00};
    localparam logic [20:0] V_F_TO    = {4'd0,  8'b0000_0000, 2'b01, 2'b00, 3'b010, 2'b01};
    localparam logic [20:0] V_DEC     = {4'd1,  8'b0000_0000, 2'b11, 2'b00, 3'b010, 2'b00};
    localparam logic [20:0] V_DEC_ILL = {4'd1,  8'b0000_0000, 2'b11, 2'b00, 3'b010, 2'b10};
    localparam logic [20:0] V_MEMADR  = {4'd2,  8'b0000_0001, 2'b10, 2'b00, 3'b010, 2'b00};
    localparam logic [20:0] V_MEMRD   = {4'd3,  8'b0100_0000, 2'b00, 2'b00, 3'b010, 2'b00};
    localparam logic [20:0] V_MEMWB   = {4'd4,  8'b0000_0110, 2'b00, 2'b00, 3'b010, 2'b00};
    localparam logic [20:0] V_MEMWR   = {4'd5,  8'b0110_0000, 2'b00, 2'b00, 3'b010, 2'b00};
    localparam logic [20:0] V_MEMWR_N = {4'd5,  8'b0100_0000, 2'b00, 2'b00, 3'b010, 2'b00};
    localparam logic [20:0] V_WR_TO   = {4'd5,  8'b0100_0000, 2'b00, 2'b00, 3'b010, 2'b01};
    localparam logic [20:0] V_ADDIEX  = {4'd9,  8'b0000_0001, 2'b10, 2'b00, 3'b010, 2'b00};
    localparam logic [20:0] V_ADDIWB  = {4'd10, 8'b0000_0010, 2'b00, 2'b00, 3'b010, 2'b00};
    localparam logic [20:0] V_JEX     = {4'd11, 8'b1000_0000, 2'b00, 2'b10, 3'b010, 2'b00};
    localparam logic [20:0] V_BEQ_T   = {4'd8,  8'b1000_0001, 2'b00, 2'b01, 3'b110, 2'b00};
    localparam logic [20:0] V_BEQ_N   = {4'd8,  8'b0000_0001, 2'b00, 2'b01, 3'b110, 2'b00};
    localparam logic [20:0] V_BNE_T   = {4'd12, 8'b1000_0001, 2'b00, 2'b01, 3'b110, 2'b00};
    localparam logic [20:0] V_BNE_N   = {4'd12, 8'b0000_0001, 2'b00, 2'b01, 3'b110, 2'b00};

    multicycle_controller #(.TIMEOUT(4), .CNT_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcen(pcen), .iord(iord), .memwrite(memwrite),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .illegal(illegal), .mem_timeout(mem_timeout), .state(state)
    );

    always #5 clk = ~clk;

    // Reset applied on exactly one rising edge; returns just after it.
    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; op = 6'b100011; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (obs !== V_F_WAIT) begin
                n_err++; $display("FAIL reset[%0d] got %h exp %h", i, obs, V_F_WAIT);
            end
        end
    endtask

    task automatic test_lw();
        logic [20:0] ev [6];
        ev = '{V_F_RDY, V_DEC, V_MEMADR, V_MEMRD, V_MEMWB, V_F_RDY};
        do_reset();
        op = 6'b100011;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); mem_ready = 1'b1; #1;
            n_cmp++;
            if (obs !== ev[i]) begin
                n_err++; $display("FAIL lw[%0d] got %h exp %h", i, obs, ev[i]);
            end
        end
    endtask

    // Back-to-back R-type instructions, including an unsupported funct.
    task automatic test_rtype();
        logic [5:0]  fv [6];
        logic [2:0]  av [6];
        logic        lv [6];
        logic [20:0] ev [4];
        fv = '{6'b100000, 6'b101010, 6'b100010, 6'b100100, 6'b100101, 6'b111111};
        av = '{3'b010,    3'b111,    3'b110,    3'b000,    3'b001,    3'b010};
        lv = '{1'b1,      1'b1,      1'b1,      1'b1,      1'b1,      1'b0};
        do_reset();
        op = 6'b000000;
        for (int k = 0; k < 6; k++) begin
            ev[0] = V_F_RDY;
            ev[1] = V_DEC;
            ev[2] = {4'd6, 8'b0000_0001, 2'b00, 2'b00, av[k], 2'b00};
            ev[3] = lv[k] ? {4'd7, 8'b0000_1010, 2'b00, 2'b00, 3'b010, 2'b00}
                          : {4'd7, 8'b0000_1000, 2'b00, 2'b00, 3'b010, 2'b10};
            for (int i = 0; i < 4; i++) begin
                @(negedge clk); mem_ready = 1'b1;
                if (i == 0) funct = fv[k];
                #1;
                n_cmp++;
                if (obs !== ev[i]) begin
                    n_err++; $display("FAIL rtype[%0d][%0d] got %h exp %h", k, i, obs, ev[i]);
                end
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0]  ov [4];
        logic        zv [4];
        logic [20:0] xv [4];
        logic [20:0] ev [3];
        ov = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
        zv = '{1'b1, 1'b0, 1'b0, 1'b1};
`ifdef MC_CTRL_BNE_EN
        xv = '{V_BEQ_T, V_BEQ_N, V_BNE_T, V_BNE_N};
`else
        xv = '{V_BEQ_T, V_BEQ_N, V_DEC_ILL, V_DEC_ILL};
`endif
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ev[0] = V_F_RDY;
            if (k < 2) begin
                ev[1] = V_DEC;
                ev[2] = xv[k];
            end else begin
`ifdef MC_CTRL_BNE_EN
                ev[1] = V_DEC;
                ev[2] = xv[k];
`else
                ev[1] = xv[k];
                ev[2] = V_F_WAIT;
`endif
            end
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                mem_ready = (i == 0);
                op = ov[k]; zero = zv[k];
                #1;
                n_cmp++;
                if (obs !== ev[i]) begin
                    n_err++; $display("FAIL branch[%0d][%0d] got %h exp %h", k, i, obs, ev[i]);
                end
            end
        end
    endtask

    task automatic test_illegal_op();
        logic [20:0] ev [4];
        ev = '{V_F_RDY, V_DEC_ILL, V_F_WAIT, V_F_WAIT};
        do_reset();
        op = 6'b111111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ready = (i == 0); #1;
            n_cmp++;
            if (obs !== ev[i]) begin
                n_err++; $display("FAIL illegal_op[%0d] got %h exp %h", i, obs, ev[i]);
            end
        end
    endtask

    task automatic test_addi_jump();
        logic [5:0]  ov [8];
        logic [20:0] ev [8];
        ov = '{6'b001000, 6'b001000, 6'b001000, 6'b001000,
               6'b000010, 6'b000010, 6'b000010, 6'b000010};
        ev = '{V_F_RDY, V_DEC, V_ADDIEX, V_ADDIWB, V_F_RDY, V_DEC, V_JEX, V_F_WAIT};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            op = ov[i];
            mem_ready = (i == 0) || (i == 4);
            #1;
            n_cmp++;
            if (obs !== ev[i]) begin
                n_err++; $display("FAIL addi_jump[%0d] got %h exp %h", i, obs, ev[i]);
            end
        end
    endtask

    // sw stall: timeout in MEMWR, then a FETCH timeout; second pass completes on the last cycle.
    task automatic test_timeout();
        logic        rv [12];
        logic [20:0] ev [12];
        rv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        ev = '{V_F_RDY, V_DEC, V_MEMADR, V_MEMWR, V_MEMWR, V_MEMWR, V_WR_TO,
               V_F_WAIT, V_F_WAIT, V_F_WAIT, V_F_TO, V_F_WAIT};
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            op = 6'b101011;
            if (pass == 1) begin
                rv[6] = 1'b1;
                ev[6] = V_MEMWR;
            end
            for (int i = 0; i < ((pass == 0) ? 12 : 8); i++) begin
                @(negedge clk); mem_ready = rv[i]; #1;
                n_cmp++;
                if (obs !== ev[i]) begin
                    n_err++; $display("FAIL timeout[%0d][%0d] got %h exp %h", pass, i, obs, ev[i]);
                end
            end
        end
    endtask

    // Reset during MEMWR: write suppressed, FETCH after, counter restarted.
    task automatic test_reset_midwrite();
        logic        rv [4];
        logic [20:0] ev [4];
        logic [20:0] fv [4];
        rv = '{1'b1, 1'b0, 1'b0, 1'b0};
        ev = '{V_F_RDY, V_DEC, V_MEMADR, V_MEMWR};
        fv = '{V_F_WAIT, V_F_WAIT, V_F_WAIT, V_F_TO};
        do_reset();
        op = 6'b101011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ready = rv[i]; #1;
            n_cmp++;
            if (obs !== ev[i]) begin
                n_err++; $display("FAIL rst_mid_pre[%0d] got %h exp %h", i, obs, ev[i]);
            end
        end
        @(negedge clk); reset_n = 1'b0; mem_ready = 1'b0; #1;
        n_cmp++;
        if (obs !== V_MEMWR_N) begin
            n_err++; $display("FAIL rst_mid_hold got %h exp %h", obs, V_MEMWR_N);
        end
        @(posedge clk); #1; reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ready = 1'b0; #1;
            n_cmp++;
            if (obs !== fv[i]) begin
                n_err++; $display("FAIL rst_mid_post[%0d] got %h exp %h", i, obs, fv[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_branch();
        test_illegal_op();
        test_addi_jump();
        test_timeout();
        test_reset_midwrite();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter TIMEOUT, default 16: max wait cycles for mem_ready per memory state; 0 disables the timeout.
REQ-002 Parameter CNT_W, default 5: wait-counter width; SHALL hold TIMEOUT.
REQ-003 clk  in  1  sole clock, rising edge; reset is synchronous and active-low.
REQ-004 reset_n  in  1  synchronous active-low reset.
REQ-005 op  in  6  instruction opcode from IR.
REQ-006 funct  in  6  R-type function field.
REQ-007 zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  memory completion handshake.
REQ-009 pcen  out  1  PC load enable.
REQ-010 iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca  out  1 each  datapath controls.
REQ-011 alusrcb  out  2  00 regB, 01 const 4, 10 signimm, 11 signimm<<2.
REQ-012 pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-013 alucontrol  out  3  ALU operation.
REQ-014 illegal  out  1  one-cycle pulse on an unsupported opcode or funct.
REQ-015 mem_timeout  out  1  one-cycle pulse on a handshake timeout.
REQ-016 state  out  4  current state encoding, for debug.

Function
REQ-017 States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, BNEEX 12.
REQ-018 FETCH outputs: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. irwrite and pcwrite are 1 only in the cycle mem_ready=1. The state holds in FETCH until mem_ready=1, then goes to DECODE.
REQ-019 DECODE: alusrcb=11, aluop=00. Next state by op:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 -> RTYPEEX
- 000100 -> BEQEX
- 001000 -> ADDIEX
- 000010 -> JEX
- any other op -> FETCH, with illegal=1 in this cycle.
REQ-020 MEMADR: alusrca=1, alusrcb=10, aluop=00. Next: lw -> MEMRD, sw -> MEMWR.
REQ-021 MEMRD: iord=1. Holds until mem_ready=1, then -> MEMWB.
REQ-022 MEMWR: iord=1, memwrite=1 for every cycle spent in the state. Holds until mem_ready=1, then -> FETCH.
REQ-023 MEMWB: regdst=0, memtoreg=1, regwrite=1, then -> FETCH.
REQ-024 RTYPEEX: alusrca=1, alusrcb=00, aluop=10, then -> RTYPEWB. RTYPEWB: regdst=1, memtoreg=0, regwrite=1, then -> FETCH.
REQ-025 BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, then -> FETCH.
REQ-026 ADDIEX: alusrca=1, alusrcb=10, aluop=00, then -> ADDIWB. ADDIWB: regdst=0, memtoreg=0, regwrite=1, then -> FETCH.
REQ-027 JEX: pcsrc=10, pcwrite=1, then -> FETCH.
REQ-028 pcen = pcwrite | (branch & zero) | (branchne & ~zero).
REQ-029 ALU decode:
- aluop 00 -> 010; aluop 01 -> 110.
- aluop 10 by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
- Other funct -> 010; illegal=1 and regwrite forced to 0 in RTYPEWB.
REQ-030 Wait counter:
- Clears on entering FETCH, MEMRD or MEMWR; increments each cycle the state waits with mem_ready=0.
- If TIMEOUT≠0 and the counter reaches TIMEOUT-1 with mem_ready=0: mem_timeout=1, irwrite/pcwrite/memwrite forced to 0 that cycle, next state FETCH.
REQ-031 mem_ready=1 in the same cycle as the timeout condition: completion wins, no mem_timeout.
REQ-032 Control signals not listed for a state are 0.

Reset
REQ-033 reset_n=0 at a rising edge: state=FETCH, counter=0.
REQ-034 While reset_n=0: pcen, irwrite, memwrite, regwrite, illegal and mem_timeout are 0 regardless of state or mem_ready.
REQ-035 Reset asserted mid-instruction (any state) abandons it; the next state after release is FETCH.

Configuration
REQ-036 Macro MC_CTRL_BNE_EN.
- Defined: op 000101 in DECODE -> BNEEX. BNEEX = BEQEX outputs but branchne=1 instead of branch, then -> FETCH.
- Undefined: 000101 is illegal; BNEEX is unreachable; branchne is tied to 0.

Verification
REQ-037 lw, mem_ready held 1: state sequence 0,1,2,3,4,0; regwrite=1 only in state 4; pcen=1 only in the FETCH cycle.
REQ-038 add (funct 100000) then slt (101010): alucontrol=010 then 111 in RTYPEEX; regdst=1 and regwrite=1 in RTYPEWB.
REQ-039 beq with zero=1 gives pcen=1 in BEQEX; zero=0 gives pcen=0. With MC_CTRL_BNE_EN defined, bne gives the opposite result; undefined, bne gives illegal=1 in DECODE.
REQ-040 TIMEOUT=4, sw, mem_ready=0: memwrite=1 for 3 cycles, then mem_timeout=1 and memwrite=0, next state FETCH. Repeat with mem_ready=1 on the 4th wait cycle: completes normally, no mem_timeout.
REQ-041 op=111111: illegal=1 for exactly one cycle in DECODE, then FETCH; no regwrite or memwrite at any point.
REQ-042 reset_n=0 for one edge while in MEMWR: memwrite=0 in that cycle, state=FETCH after the edge, counter=0.
